// File: rtl/npc_pkg.sv
// Shared NPC core types and constants: fetch FSM states, fetch fault codes,
// the canonical NOP encoding and the PC reset vector.
package npc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NPC_RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] NPC_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        FETCH_OK       = 2'b00,
        FETCH_MISALIGN = 2'b01,
        FETCH_ACCERR   = 2'b10,
        FETCH_TIMEOUT  = 2'b11
    } fetch_fault_e;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Saturating wait-cycle counter with clear and enable; expire_c flags the
// enabled increment that brings the count up to LIMIT.
module ifu_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign expire_c = en && (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word read per PC over a valid/ready
// channel, waits for the response (with timeout) and holds it for decode.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = NPC_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_update,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    output logic [31:0] fetch_cnt
);

    // Elaboration-time sanity checks on the configuration.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("ifu_fetch: RESET_PC must be word aligned");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ifu_fetch: TIMEOUT must be at least 1");
    end

    fetch_state_e state_q, state_d;
    fetch_fault_e fault_q, fault_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;

    logic pc_misalign_c;
    logic ctr_clr;
    logic ctr_en;
    logic ctr_expire_c;

    ifu_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .expire_c (ctr_expire_c)
    );

    assign pc_misalign_c  = |pc_in[1:0];
    assign imem_req_valid = !rst && (state_q == ST_REQ) && !pc_misalign_c;
    assign imem_req_addr  = pc_in;
    assign inst_valid     = (state_q == ST_HOLD);
    assign pc_update      = inst_valid && inst_ready;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = fault_q;
    assign fetch_cnt      = fetch_cnt_q;

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (pc_misalign_c) begin
                    inst_pc_d = pc_in;
                    inst_d    = NOP_INST;
                    fault_d   = FETCH_MISALIGN;
                    state_d   = ST_HOLD;
                end else if (imem_req_valid && imem_req_ready) begin
                    inst_pc_d = pc_in;
                    ctr_clr   = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response on the expiry cycle takes priority over the timeout.
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_err ? NOP_INST : imem_rsp_data;
                    fault_d = imem_rsp_err ? FETCH_ACCERR : FETCH_OK;
                    state_d = ST_HOLD;
                end else begin
                    ctr_en = 1'b1;
                    if (ctr_expire_c) begin
                        inst_d  = NOP_INST;
                        fault_d = FETCH_TIMEOUT;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            fault_q     <= FETCH_OK;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule
